// File: rtl/imem_fetch_responder_if.sv
// Fetch-side and external-memory-side signals of the instruction fetch responder.
// The slave modport is the responder; the master modport is the fetch stage plus memory.
interface imem_fetch_responder_if #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 32,
    parameter int EXT_W   = 8
);
    logic [ADDR_W-1:0]  imem_addr_i;
    logic               flush_i;
    logic [INSTR_W-1:0] instr_o;
    logic               instr_valid_o;
    logic               halt_o;
    logic               ext_req_o;
    logic [ADDR_W+1:0]  ext_addr_o;
    logic               ext_ack_i;
    logic [EXT_W-1:0]   ext_data_i;
    logic [15:0]        miss_cnt_o;

    modport slave (
        input  imem_addr_i, flush_i, ext_ack_i, ext_data_i,
        output instr_o, instr_valid_o, halt_o, ext_req_o, ext_addr_o, miss_cnt_o
    );

    modport master (
        output imem_addr_i, flush_i, ext_ack_i, ext_data_i,
        input  instr_o, instr_valid_o, halt_o, ext_req_o, ext_addr_o, miss_cnt_o
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// One-entry tagged line buffer in front of byte-wide instruction memory; a miss
// is filled big-endian over four request/acknowledge beats while halting fetch.
module imem_fetch_responder #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 32,
    parameter int EXT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    imem_fetch_responder_if.slave  bus
);
    localparam int BEATS  = INSTR_W / EXT_W;
    localparam int BEAT_W = 2;

    typedef enum logic [0:0] {IDLE, FETCH} state_t;

    state_t             state_q, state_d;
    logic               line_valid_q;
    logic [ADDR_W-1:0]  line_tag_q;
    logic [INSTR_W-1:0] line_data_q;
    logic [ADDR_W-1:0]  miss_addr_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [INSTR_W-1:0] asm_q, asm_d;
    logic [15:0]        miss_cnt_q;
    logic               hit, start_miss, take_beat, last_beat, fill, abort;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        start_miss = 1'b0;
        take_beat  = 1'b0;
        fill       = 1'b0;
        abort      = 1'b0;
        hit        = line_valid_q && (line_tag_q == bus.imem_addr_i) && (state_q == IDLE);
        last_beat  = (beat_q == BEAT_W'(BEATS - 1));
        case (state_q)
            IDLE: begin
                if (!bus.flush_i && !hit) begin
                    start_miss = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                // Flush outranks a same-cycle ack: the partial word is dropped.
                if (bus.flush_i) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (bus.ext_ack_i) begin
                    take_beat = 1'b1;
                    if (last_beat) begin
                        fill    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat 0 lands in the most significant byte lane.
    always_comb begin
        asm_d = asm_q;
        asm_d[(BEATS - 1 - int'(beat_q)) * EXT_W +: EXT_W] = bus.ext_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid_q <= 1'b0;
            line_tag_q   <= '0;
            line_data_q  <= '0;
            miss_addr_q  <= '0;
            beat_q       <= '0;
            asm_q        <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (start_miss) begin
                miss_addr_q <= bus.imem_addr_i;
                beat_q      <= '0;
                miss_cnt_q  <= sat_inc16(miss_cnt_q);
            end
            if (take_beat) begin
                asm_q  <= asm_d;
                beat_q <= beat_q + BEAT_W'(1);
            end
            if (abort) beat_q <= '0;
            if (fill) begin
                line_tag_q   <= miss_addr_q;
                line_data_q  <= asm_d;
                line_valid_q <= 1'b1;
            end
            if (bus.flush_i) line_valid_q <= 1'b0;
        end
    end

    assign bus.instr_o       = line_data_q;
    assign bus.instr_valid_o = hit;
    assign bus.halt_o        = !hit;
    assign bus.ext_req_o     = (state_q == FETCH);
    assign bus.ext_addr_o    = {miss_addr_q, beat_q};
    assign bus.miss_cnt_o    = miss_cnt_q;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: byte memory model plus hand-computed
// expected words, ext_addr sequences and miss counts.
module tb_imem_fetch_responder;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] mem [0:16383];
    int n_cmp = 0;
    int n_err = 0;

    imem_fetch_responder_if bus();

    imem_fetch_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.ext_data_i = mem[bus.ext_addr_o];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        {mem[14'h0000], mem[14'h0001], mem[14'h0002], mem[14'h0003]} = 32'h12345678;
        {mem[14'h0014], mem[14'h0015], mem[14'h0016], mem[14'h0017]} = 32'hA1B2C3D4;
        {mem[14'h001C], mem[14'h001D], mem[14'h001E], mem[14'h001F]} = 32'hDEADBEEF;
        {mem[14'h0040], mem[14'h0041], mem[14'h0042], mem[14'h0043]} = 32'h11223344;
        {mem[14'h0080], mem[14'h0081], mem[14'h0082], mem[14'h0083]} = 32'h55667788;
        {mem[14'h3FFC], mem[14'h3FFD], mem[14'h3FFE], mem[14'h3FFF]} = 32'hCAFEBABE;

        rst = 1'b1;
        bus.imem_addr_i = 12'h000;
        bus.flush_i = 1'b0;
        bus.ext_ack_i = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("rst_halt", 32'(bus.halt_o), 32'd1);
        chk("rst_req", 32'(bus.ext_req_o), 32'd0);
        chk("rst_addr", 32'(bus.ext_addr_o), 32'h0);
        chk("rst_instr", bus.instr_o, 32'h0);
        chk("rst_cnt", 32'(bus.miss_cnt_o), 32'd0);

        // Miss on word 0 with ack tied high: halt cycles 0-4, hit in cycle 5.
        rst = 1'b0;
        bus.ext_ack_i = 1'b1;
        #1;
        chk("m0_c0_halt", 32'(bus.halt_o), 32'd1);
        chk("m0_c0_req", 32'(bus.ext_req_o), 32'd0);
        for (int b = 0; b < 4; b++) begin
            cyc();
            chk("m0_req", 32'(bus.ext_req_o), 32'd1);
            chk("m0_addr", 32'(bus.ext_addr_o), 32'(b));
            chk("m0_halt", 32'(bus.halt_o), 32'd1);
        end
        cyc();
        chk("m0_instr", bus.instr_o, 32'h12345678);
        chk("m0_valid", 32'(bus.instr_valid_o), 32'd1);
        chk("m0_halt5", 32'(bus.halt_o), 32'd0);
        chk("m0_cnt", 32'(bus.miss_cnt_o), 32'd1);
        chk("m0_req5", 32'(bus.ext_req_o), 32'd0);

        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("hold_valid", 32'(bus.instr_valid_o), 32'd1);
            chk("hold_req", 32'(bus.ext_req_o), 32'd0);
        end
        chk("hold_cnt", 32'(bus.miss_cnt_o), 32'd1);

        // Miss on 0x005 with an ack every third cycle.
        bus.imem_addr_i = 12'h005;
        bus.ext_ack_i = 1'b0;
        #1;
        chk("m5_c0_halt", 32'(bus.halt_o), 32'd1);
        cyc();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 3; k++) begin
                bus.ext_ack_i = (k == 2);
                #1;
                chk("m5_req", 32'(bus.ext_req_o), 32'd1);
                chk("m5_addr", 32'(bus.ext_addr_o), 32'h14 + 32'(b));
                chk("m5_valid", 32'(bus.instr_valid_o), 32'd0);
                cyc();
            end
        end
        bus.ext_ack_i = 1'b0;
        #1;
        chk("m5_instr", bus.instr_o, 32'hA1B2C3D4);
        chk("m5_hit", 32'(bus.instr_valid_o), 32'd1);
        chk("m5_cnt", 32'(bus.miss_cnt_o), 32'd2);

        // Address changes mid-fetch: 0x010 completes, then 0x020 misses.
        bus.imem_addr_i = 12'h010;
        bus.ext_ack_i = 1'b1;
        cyc();
        chk("m10_a0", 32'(bus.ext_addr_o), 32'h40);
        cyc();
        chk("m10_a1", 32'(bus.ext_addr_o), 32'h41);
        bus.imem_addr_i = 12'h020;
        cyc();
        chk("m10_a2", 32'(bus.ext_addr_o), 32'h42);
        cyc();
        chk("m10_a3", 32'(bus.ext_addr_o), 32'h43);
        chk("m10_cnt", 32'(bus.miss_cnt_o), 32'd3);
        cyc();
        chk("m10_idle_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("m10_fill", bus.instr_o, 32'h11223344);
        cyc();
        chk("m20_a0", 32'(bus.ext_addr_o), 32'h80);
        chk("m20_req", 32'(bus.ext_req_o), 32'd1);
        chk("m20_cnt", 32'(bus.miss_cnt_o), 32'd4);
        for (int i = 0; i < 4; i++) cyc();
        chk("m20_instr", bus.instr_o, 32'h55667788);
        chk("m20_valid", 32'(bus.instr_valid_o), 32'd1);

        // Flush at beat 2 of a miss on 0x007 (ack in the same cycle is ignored).
        bus.imem_addr_i = 12'h007;
        cyc();
        chk("m7_a0", 32'(bus.ext_addr_o), 32'h1C);
        cyc();
        cyc();
        chk("m7_a2", 32'(bus.ext_addr_o), 32'h1E);
        bus.flush_i = 1'b1;
        cyc();
        chk("fl_req", 32'(bus.ext_req_o), 32'd0);
        chk("fl_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("fl_halt", 32'(bus.halt_o), 32'd1);
        chk("fl_nofill", bus.instr_o, 32'h55667788);
        bus.flush_i = 1'b0;
        cyc();
        chk("m7r_a0", 32'(bus.ext_addr_o), 32'h1C);
        chk("m7r_req", 32'(bus.ext_req_o), 32'd1);
        chk("m7r_cnt", 32'(bus.miss_cnt_o), 32'd6);
        for (int i = 0; i < 4; i++) cyc();
        chk("m7r_instr", bus.instr_o, 32'hDEADBEEF);
        chk("m7r_valid", 32'(bus.instr_valid_o), 32'd1);

        // Top word wraps only in the beat bits; then reset clears everything.
        bus.imem_addr_i = 12'hFFF;
        cyc();
        chk("mf_a0", 32'(bus.ext_addr_o), 32'h3FFC);
        cyc();
        cyc();
        cyc();
        chk("mf_a3", 32'(bus.ext_addr_o), 32'h3FFF);
        cyc();
        chk("mf_instr", bus.instr_o, 32'hCAFEBABE);
        chk("mf_valid", 32'(bus.instr_valid_o), 32'd1);
        chk("mf_cnt", 32'(bus.miss_cnt_o), 32'd7);
        rst = 1'b1;
        bus.flush_i = 1'b1;
        cyc();
        rst = 1'b0;
        bus.flush_i = 1'b0;
        #1;
        chk("rs_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("rs_halt", 32'(bus.halt_o), 32'd1);
        chk("rs_cnt", 32'(bus.miss_cnt_o), 32'd0);
        chk("rs_req", 32'(bus.ext_req_o), 32'd0);
        chk("rs_instr", bus.instr_o, 32'h0);
        cyc();
        chk("rs_miss_addr", 32'(bus.ext_addr_o), 32'h3FFC);
        chk("rs_miss_req", 32'(bus.ext_req_o), 32'd1);
        chk("rs_miss_cnt", 32'(bus.miss_cnt_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
